// File: rtl/crack_scheduler.sv
// -----------------------------------------------------------------------------
// crack_scheduler
//
// Launches N_WORKERS ARC4 crack engines on interleaved key sequences and
// collects a single result for the host. Worker i starts at base_key + i and
// every worker steps by N_WORKERS. The lowest-indexed worker that reports a
// valid key wins. Once a result is known (or the search is aborted or
// exhausted) every worker is frozen.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   en, base_key        : host start request and first key (taken while rdy=1)
//   pause, abort        : host freeze / cancel (only honoured in RUN)
//   rdy, key, key_valid : host result interface
//   w_rst_n, w_en       : per-worker active-low reset and one-cycle start pulse
//   w_start_key         : packed per-worker start keys, worker i at [i*KEY_W +: KEY_W]
//   w_step_key          : common key step (constant N_WORKERS)
//   w_stop              : per-worker freeze
//   w_rdy, w_key_valid  : per-worker finished / found-key flags
//   w_key               : packed per-worker found keys
//   cycles              : RUN cycle counter, present only with
//                         CRACK_SCHED_CYCCNT_EN defined
//
// Every output is driven straight from a flop; none depends combinationally
// on an input.
// -----------------------------------------------------------------------------
module crack_scheduler #(
    parameter int N_WORKERS = 2,
    parameter int KEY_W     = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [KEY_W-1:0]             base_key,
    input  logic                         pause,
    input  logic                         abort,
    output logic                         rdy,
    output logic [KEY_W-1:0]             key,
    output logic                         key_valid,
    output logic [N_WORKERS-1:0]         w_rst_n,
    output logic [N_WORKERS-1:0]         w_en,
    output logic [N_WORKERS*KEY_W-1:0]   w_start_key,
    output logic [KEY_W-1:0]             w_step_key,
    output logic [N_WORKERS-1:0]         w_stop,
    input  logic [N_WORKERS-1:0]         w_rdy,
    input  logic [N_WORKERS-1:0]         w_key_valid,
    input  logic [N_WORKERS*KEY_W-1:0]   w_key
`ifdef CRACK_SCHED_CYCCNT_EN
    ,
    output logic [31:0]                  cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [KEY_W-1:0]             base_key_q, base_key_d;
    logic [N_WORKERS*KEY_W-1:0]   start_key_q, start_key_d;
    logic [N_WORKERS-1:0]         active_q, active_d;
    logic [N_WORKERS-1:0]         done_q, done_d;
    logic [KEY_W-1:0]             key_q, key_d;
    logic                         key_valid_q, key_valid_d;
    logic                         rdy_q, rdy_d;
    logic [N_WORKERS-1:0]         w_rst_n_q, w_rst_n_d;
    logic [N_WORKERS-1:0]         w_en_q, w_en_d;
    logic [N_WORKERS-1:0]         w_stop_q, w_stop_d;
`ifdef CRACK_SCHED_CYCCNT_EN
    logic [31:0]                  cycles_q, cycles_d;
`endif

    // Winner selection scratch values
    logic                         win_found;
    logic [KEY_W-1:0]             win_key;
    logic [KEY_W:0]               start_sum;

    // Step is the worker count; it never changes, so it is not a register.
    assign w_step_key = KEY_W'(N_WORKERS);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred; blocking (=) is used
    // because this is combinational logic.
    always_comb begin
        state_d     = state_q;
        base_key_d  = base_key_q;
        start_key_d = start_key_q;
        active_d    = active_q;
        done_d      = done_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        rdy_d       = rdy_q;
        w_rst_n_d   = '1;
        w_en_d      = '0;
        w_stop_d    = w_stop_q;
        start_sum   = '0;
`ifdef CRACK_SCHED_CYCCNT_EN
        cycles_d    = cycles_q;
`endif

        // Scan from the top down so the lowest qualifying index wins.
        win_found = 1'b0;
        win_key   = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            if (w_rdy[i] && w_key_valid[i] && active_q[i]) begin
                win_found = 1'b1;
                win_key   = w_key[i*KEY_W +: KEY_W];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (en) begin
                    state_d     = S_CLEAR;
                    base_key_d  = base_key;
                    rdy_d       = 1'b0;
                    key_valid_d = 1'b0;
                    w_rst_n_d   = '0;
                    w_stop_d    = '0;
                end
            end

            S_CLEAR: begin
                // A start key that wraps past KEY_W bits is outside the
                // search space: that worker never runs and counts as done.
                for (int i = 0; i < N_WORKERS; i++) begin
                    start_sum = {1'b0, base_key_q} + (KEY_W+1)'(i);
                    start_key_d[i*KEY_W +: KEY_W] = start_sum[KEY_W-1:0];
                    active_d[i] = ~start_sum[KEY_W];
                    done_d[i]   = start_sum[KEY_W];
                    w_en_d[i]   = ~start_sum[KEY_W];
                end
`ifdef CRACK_SCHED_CYCCNT_EN
                cycles_d = '0;
`endif
                state_d = S_LAUNCH;
            end

            S_LAUNCH: begin
                w_stop_d = '0;
                state_d  = S_RUN;
            end

            S_RUN: begin
                done_d   = done_q | (w_rdy & active_q);
                w_stop_d = {N_WORKERS{pause}};
`ifdef CRACK_SCHED_CYCCNT_EN
                if (!pause && cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
`endif
                if (win_found) begin
                    key_d       = win_key;
                    key_valid_d = 1'b1;
                    state_d     = S_DONE;
                    rdy_d       = 1'b1;
                    w_stop_d    = '1;
                end else if (abort || (&done_d)) begin
                    key_valid_d = 1'b0;
                    state_d     = S_DONE;
                    rdy_d       = 1'b1;
                    w_stop_d    = '1;
                end
            end

            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_key_q  <= '0;
            start_key_q <= '0;
            active_q    <= '0;
            done_q      <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            w_rst_n_q   <= '1;
            w_en_q      <= '0;
            w_stop_q    <= '0;
`ifdef CRACK_SCHED_CYCCNT_EN
            cycles_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_key_q  <= base_key_d;
            start_key_q <= start_key_d;
            active_q    <= active_d;
            done_q      <= done_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            rdy_q       <= rdy_d;
            w_rst_n_q   <= w_rst_n_d;
            w_en_q      <= w_en_d;
            w_stop_q    <= w_stop_d;
`ifdef CRACK_SCHED_CYCCNT_EN
            cycles_q    <= cycles_d;
`endif
        end
    end

    assign rdy         = rdy_q;
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign w_rst_n     = w_rst_n_q;
    assign w_en        = w_en_q;
    assign w_start_key = start_key_q;
    assign w_stop      = w_stop_q;
`ifdef CRACK_SCHED_CYCCNT_EN
    assign cycles      = cycles_q;
`endif

endmodule
